instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//  Front-end of the CPU. Feeds the execute/decode stage: keeps the program counter and issues reads
//  to the synchronous 16-word instruction memory. It buffers the returned instructions, with
//  their PCs, in a small prefetch FIFO and hands them downstream over a valid/ready handshake.
//  It supports a PC redirect (branch/jump from execute) and stops fetching after a HALT opcode.
// PARAMETERS
//  ADDR_W       4      instruction memory address width (PC width); 16 words
//  INSTR_W      16     instruction width; opcode = instr[15:12], op1 = [11:8], op2 = [7:4]
//  DEPTH        4      prefetch FIFO entries (power of 2, >= 2)
//  HALT_OPCODE  4'hF   opcode that stops further fetching
// PORTS
//  clk             in   1        clock, rising edge
//  rst             in   1        synchronous reset, active-high
//  imem_en         out  1        read strobe to instruction memory
//  imem_addr       out  ADDR_W   read address (current fetch PC)
//  imem_rdata      in   INSTR_W  read data, valid the cycle after imem_en
//  redirect_valid  in   1        load new PC, flush all prefetched/in-flight work
//  redirect_pc     in   ADDR_W   target PC for redirect
//  out_valid       out  1        out_instr/out_pc hold a valid instruction
//  out_ready       in   1        downstream accepts; pop when out_valid && out_ready
//  out_instr       out  INSTR_W  FIFO head instruction (0 when empty)
//  out_pc          out  ADDR_W   PC of out_instr (0 when empty)
//  halted          out  1        HALT instruction has been captured; fetching stopped
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): fetch_pc=0, FIFO empty, in-flight=0, halted=0.
//    While rst=1: imem_en=0, out_valid=0, out_instr=0, out_pc=0.
//  - Issue: imem_en=1 in a cycle iff !rst && !redirect_valid && !halted && (fifo_count+inflight) < DEPTH.
//    Credit ignores a same-cycle pop (conservative). On issue, record inflight=1 and inflight_pc=fetch_pc.
//    Then fetch_pc <= fetch_pc+1, mod 2^ADDR_W (15 -> 0).
//  - Response: a read issued in cycle N presents imem_rdata in N+1 and is pushed {rdata, pc} at the end of N+1.
//    First out_valid is the 2nd cycle after issue; sustained 1 instr/cycle with out_ready=1.
//  - Drop rule: a response is discarded (not pushed) if redirect_valid or rst is high in its arrival cycle,
//    if a redirect or reset occurred in its issue cycle, or if halted=1 when it arrives.
//  - Halt: pushing an instruction with opcode==HALT_OPCODE sets halted=1 the next cycle.
//    The HALT instruction itself is delivered downstream. The one read already issued behind it is dropped.
//    halted clears only on redirect or reset.
//  - Redirect (redirect_valid=1 at edge): FIFO flushed, in-flight killed, fetch_pc <= redirect_pc, halted <= 0.
//    In that cycle out_valid is forced 0, no pop occurs and imem_en=0. Fetch resumes next cycle at redirect_pc.
//  - Output: out_valid = !fifo_empty && !redirect_valid. out_instr/out_pc stable while out_valid && !out_ready.
//  - FIFO: circular, read/write pointers wrap mod DEPTH. Simultaneous push and pop while full or empty is legal
//    (count unchanged / passes through next cycle). Overflow is impossible by the credit rule.
//  - Reset mid-operation: all buffered and in-flight instructions lost; restart from PC 0.
// TESTING
//  1 mem[0]=16'h0120, mem[1]=16'h1210, mem[2]=16'hF000, out_ready=1, release rst -> pc0 out_valid 2 cyc
//    after first imem_en; outputs (pc,instr) = (0,0120), (1,1210), (2,F000); halted=1; no further out_valid
//    or imem_en; pc3 never delivered.
//  2 out_ready=0 after reset -> exactly 4 issues (addr 0..3), then imem_en=0 with 4 entries held;
//    raise out_ready -> pcs 0,1,2,3,4,... in order, no gap/dup.
//  3 FIFO holding pcs 0,1 and read of pc2 in flight, pulse redirect_valid with redirect_pc=9 ->
//    out_valid=0 that cycle; next delivered pc is 9, pcs 0..2 never appear.
//  4 redirect_pc=14, mem[14]=16'h3450, mem[15]=16'h2100, mem[0]=16'h0120 -> delivered pcs 14,15,0
//    (address wraps).
//  5 FIFO with 3 entries, assert rst one cycle -> out_valid=0 during reset; the cycle after reset shows no
//    stale data; fetch restarts at addr 0.
//  6 After HALT (halted=1), redirect to pc 5 -> halted=0 next cycle; fetch resumes, pc5 delivered.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//   CPU front-end. Holds the fetch PC, issues reads to a synchronous
//   instruction memory (one-cycle read latency), buffers the returned
//   instructions with their PCs in a small prefetch FIFO and hands them
//   downstream over a valid/ready handshake. A redirect reloads the PC and
//   flushes all buffered and in-flight work. Fetching stops once a HALT
//   opcode has been captured.
//
// Ports
//   i_clk              clock, rising edge
//   i_rst              synchronous reset, active-high
//   o_imem_en          read strobe to instruction memory
//   o_imem_addr        read address (current fetch PC)
//   i_imem_rdata       read data, valid the cycle after o_imem_en
//   i_redirect_valid   load i_redirect_pc, flush prefetched/in-flight work
//   i_redirect_pc      redirect target PC
//   o_out_valid        o_out_instr/o_out_pc hold a valid instruction
//   i_out_ready        downstream accepts (pop on valid && ready)
//   o_out_instr        FIFO head instruction (0 when empty or in reset)
//   o_out_pc           PC of o_out_instr (0 when empty or in reset)
//   o_halted           HALT captured; fetching stopped
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned INSTR_W     = 16,
   parameter int unsigned DEPTH       = 4,
   parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
   input  logic               i_clk,
   input  logic               i_rst,
   output logic               o_imem_en,
   output logic [ADDR_W-1:0]  o_imem_addr,
   input  logic [INSTR_W-1:0] i_imem_rdata,
   input  logic               i_redirect_valid,
   input  logic [ADDR_W-1:0]  i_redirect_pc,
   output logic               o_out_valid,
   input  logic               i_out_ready,
   output logic [INSTR_W-1:0] o_out_instr,
   output logic [ADDR_W-1:0]  o_out_pc,
   output logic               o_halted
);

   localparam int unsigned     PTR_W     = $clog2(DEPTH);
   localparam int unsigned     CNT_W     = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   // Fetch state
   logic [ADDR_W-1:0]  r_fetch_pc;
   logic               r_inflight;
   logic [ADDR_W-1:0]  r_inflight_pc;
   logic               r_halted;

   // Prefetch FIFO
   logic [INSTR_W-1:0] r_fifo_instr [DEPTH];
   logic [ADDR_W-1:0]  r_fifo_pc    [DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;

   logic               w_flush;
   logic               w_empty;
   logic [CNT_W-1:0]   w_credit;
   logic               w_issue;
   logic               w_push;
   logic               w_pop;
   logic               w_out_valid;
   logic               w_halt_push;

   always_comb begin
      w_flush     = i_rst | i_redirect_valid;
      w_empty     = (r_count == '0);
      // Buffered entries plus the outstanding read; a same-cycle pop is
      // deliberately not credited so the FIFO can never overflow.
      w_credit    = r_count + CNT_W'(r_inflight);
      w_issue     = !w_flush && !r_halted && (w_credit < DEPTH_CNT);
      // A response arriving after HALT was captured is the read issued
      // behind the HALT; it is discarded.
      w_push      = r_inflight && !w_flush && !r_halted;
      w_halt_push = w_push && (i_imem_rdata[INSTR_W-1 -: 4] == HALT_OPCODE);
      w_out_valid = !w_flush && !w_empty;
      w_pop       = w_out_valid && i_out_ready;
   end

   always_comb begin
      o_imem_en   = w_issue;
      o_imem_addr = r_fetch_pc;
      o_out_valid = w_out_valid;
      o_halted    = r_halted;
      o_out_instr = '0;
      o_out_pc    = '0;
      if (!i_rst && !w_empty) begin
         o_out_instr = r_fifo_instr[r_rd_ptr];
         o_out_pc    = r_fifo_pc[r_rd_ptr];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_fetch_pc    <= '0;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
         r_halted      <= 1'b0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
      end else if (i_redirect_valid) begin
         r_fetch_pc    <= i_redirect_pc;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
         r_halted      <= 1'b0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_inflight_pc <= r_fetch_pc;
            r_fetch_pc    <= r_fetch_pc + 1'b1;
         end
         if (w_halt_push) begin
            r_halted <= 1'b1;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // Storage needs no reset: contents are only visible through r_count.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fifo_instr[r_wr_ptr] <= i_imem_rdata;
         r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_queue
//   Directed scenarios followed by a randomized phase. A queue-based reference
//   model tracks which instructions are buffered or outstanding and what must
//   appear at the outputs every cycle.
// -----------------------------------------------------------------------------
module tb_instr_fetch_queue;

   localparam int unsigned ADDR_W  = 4;
   localparam int unsigned INSTR_W = 16;
   localparam int unsigned DEPTH   = 4;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } ent_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               imem_en;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_rdata = '0;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_pc;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [ADDR_W-1:0]  out_pc;
   logic               halted;

   logic [INSTR_W-1:0] mem [16];

   always #5 clk = ~clk;

   // Synchronous instruction memory, one-cycle read latency
   always @(posedge clk) begin
      if (imem_en) imem_rdata <= mem[imem_addr];
   end

   instr_fetch_queue #(
      .ADDR_W      (ADDR_W),
      .INSTR_W     (INSTR_W),
      .DEPTH       (DEPTH),
      .HALT_OPCODE (4'hF)
   ) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .o_imem_en        (imem_en),
      .o_imem_addr      (imem_addr),
      .i_imem_rdata     (imem_rdata),
      .i_redirect_valid (redirect_valid),
      .i_redirect_pc    (redirect_pc),
      .o_out_valid      (out_valid),
      .i_out_ready      (out_ready),
      .o_out_instr      (out_instr),
      .o_out_pc         (out_pc),
      .o_halted         (halted)
   );

   // Reference model
   ent_t               m_q[$];
   bit                 m_infl = 1'b0;
   logic [ADDR_W-1:0]  m_infl_pc = '0;
   logic [INSTR_W-1:0] m_infl_instr = '0;
   bit                 m_halted = 1'b0;
   logic [ADDR_W-1:0]  m_pc = '0;

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   n_issue = 0;
   int   first_en = -1;
   int   first_valid = -1;
   ent_t dlog[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle with the currently driven inputs.
   task automatic cycle();
      bit   e_en;
      bit   e_valid;
      ent_t e;
      @(negedge clk);
      e_en    = !rst && !redirect_valid && !m_halted && (m_q.size() + int'(m_infl)) < DEPTH;
      e_valid = !rst && !redirect_valid && (m_q.size() > 0);
      chk("imem_en", 32'(imem_en), 32'(e_en));
      if (e_en) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("out_valid", 32'(out_valid), 32'(e_valid));
      if (rst || m_q.size() == 0) begin
         chk("out_pc_idle", 32'(out_pc), 32'h0);
         chk("out_instr_idle", 32'(out_instr), 32'h0);
      end else begin
         chk("out_pc", 32'(out_pc), 32'(m_q[0].pc));
         chk("out_instr", 32'(out_instr), 32'(m_q[0].instr));
      end
      if (!rst) chk("halted", 32'(halted), 32'(m_halted));
      if (imem_en) begin
         n_issue++;
         if (first_en < 0) first_en = cyc;
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_ready) begin
         e.pc    = out_pc;
         e.instr = out_instr;
         dlog.push_back(e);
      end
      @(posedge clk);
      if (rst) begin
         m_q.delete();
         m_infl   = 1'b0;
         m_halted = 1'b0;
         m_pc     = '0;
      end else if (redirect_valid) begin
         m_q.delete();
         m_infl   = 1'b0;
         m_halted = 1'b0;
         m_pc     = redirect_pc;
      end else begin
         if (e_valid && out_ready) void'(m_q.pop_front());
         if (m_infl && !m_halted) begin
            e.pc    = m_infl_pc;
            e.instr = m_infl_instr;
            m_q.push_back(e);
            if (m_infl_instr[15:12] == 4'hF) m_halted = 1'b1;
         end
         m_infl = e_en;
         if (e_en) begin
            m_infl_pc    = m_pc;
            m_infl_instr = mem[m_pc];
            m_pc         = m_pc + 1'b1;
         end
      end
      cyc++;
      #1;
   endtask

   task automatic fill_no_halt();
      for (int i = 0; i < 16; i++) begin
         mem[i] = 16'($urandom);
         if (mem[i][15:12] == 4'hF) mem[i][15:12] = 4'h0;
      end
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      cycle();
      cycle();
      rst      = 1'b0;
      dlog.delete();
      n_issue     = 0;
      first_en    = -1;
      first_valid = -1;
      cyc         = 0;
   endtask

   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b1;

      // 1: short program ending in HALT
      fill_no_halt();
      mem[0] = 16'h0120;
      mem[1] = 16'h1210;
      mem[2] = 16'hF000;
      mem[3] = 16'h1234;
      out_ready = 1'b1;
      do_reset();
      repeat (12) cycle();
      chk("t1_latency", 32'(first_valid - first_en), 32'd2);
      chk("t1_ndeliv", 32'(dlog.size()), 32'd3);
      chk("t1_pc0", 32'(dlog[0].pc), 32'd0);
      chk("t1_in0", 32'(dlog[0].instr), 32'h0120);
      chk("t1_pc1", 32'(dlog[1].pc), 32'd1);
      chk("t1_in1", 32'(dlog[1].instr), 32'h1210);
      chk("t1_pc2", 32'(dlog[2].pc), 32'd2);
      chk("t1_in2", 32'(dlog[2].instr), 32'hF000);
      chk("t1_halted", 32'(halted), 32'd1);
      chk("t1_issues", 32'(n_issue), 32'd4);

      // 2: backpressure fills the FIFO, then drain in order
      fill_no_halt();
      out_ready = 1'b0;
      do_reset();
      repeat (8) cycle();
      chk("t2_issues", 32'(n_issue), 32'd4);
      chk("t2_held", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      repeat (20) cycle();
      chk("t2_ndeliv", 32'(dlog.size()), 32'd20);
      for (int i = 0; i < dlog.size(); i++) begin
         chk("t2_pc", 32'(dlog[i].pc), 32'(i % 16));
         chk("t2_instr", 32'(dlog[i].instr), 32'(mem[i % 16]));
      end

      // 3: redirect with pcs 0,1 buffered and pc2 in flight
      fill_no_halt();
      out_ready = 1'b0;
      do_reset();
      repeat (3) cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 4'd9;
      out_ready      = 1'b1;
      #1;
      chk("t3_valid_redir", 32'(out_valid), 32'd0);
      chk("t3_en_redir", 32'(imem_en), 32'd0);
      cycle();
      redirect_valid = 1'b0;
      dlog.delete();
      repeat (8) cycle();
      chk("t3_ndeliv", 32'(dlog.size()), 32'd6);
      for (int i = 0; i < dlog.size(); i++) chk("t3_pc", 32'(dlog[i].pc), 32'(9 + i));

      // 4: PC wraps from 15 to 0
      mem[14] = 16'h3450;
      mem[15] = 16'h2100;
      mem[0]  = 16'h0120;
      redirect_valid = 1'b1;
      redirect_pc    = 4'd14;
      cycle();
      redirect_valid = 1'b0;
      dlog.delete();
      repeat (6) cycle();
      chk("t4_pc0", 32'(dlog[0].pc), 32'd14);
      chk("t4_in0", 32'(dlog[0].instr), 32'h3450);
      chk("t4_pc1", 32'(dlog[1].pc), 32'd15);
      chk("t4_in1", 32'(dlog[1].instr), 32'h2100);
      chk("t4_pc2", 32'(dlog[2].pc), 32'd0);
      chk("t4_in2", 32'(dlog[2].instr), 32'h0120);

      // 5: reset with three entries buffered
      fill_no_halt();
      out_ready = 1'b0;
      do_reset();
      repeat (4) cycle();
      chk("t5_full3", 32'(out_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("t5_valid_rst", 32'(out_valid), 32'd0);
      cycle();
      rst = 1'b0;
      #1;
      chk("t5_valid_after", 32'(out_valid), 32'd0);
      chk("t5_pc_after", 32'(out_pc), 32'd0);
      chk("t5_instr_after", 32'(out_instr), 32'd0);
      chk("t5_en_after", 32'(imem_en), 32'd1);
      chk("t5_addr_after", 32'(imem_addr), 32'd0);
      out_ready = 1'b1;
      dlog.delete();
      repeat (6) cycle();
      chk("t5_pc0", 32'(dlog[0].pc), 32'd0);

      // 6: redirect out of the halted state
      fill_no_halt();
      mem[2] = 16'hF123;
      mem[5] = 16'h5555;
      out_ready = 1'b1;
      do_reset();
      repeat (10) cycle();
      chk("t6_halted", 32'(halted), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 4'd5;
      cycle();
      redirect_valid = 1'b0;
      #1;
      chk("t6_unhalted", 32'(halted), 32'd0);
      dlog.delete();
      repeat (6) cycle();
      chk("t6_pc0", 32'(dlog[0].pc), 32'd5);
      chk("t6_in0", 32'(dlog[0].instr), 32'h5555);

      // Randomized traffic with HALTs, redirects and resets
      for (int i = 0; i < 16; i++) begin
         mem[i] = 16'($urandom);
         if ($urandom_range(0, 5) == 0) mem[i][15:12] = 4'hF;
      end
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         out_ready      = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc    = 4'($urandom);
         rst            = ($urandom_range(0, 199) == 0);
         cycle();
      end
      rst            = 1'b0;
      redirect_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
